// File: rtl/sysref_gate_if.sv
// Control/status bundle between the register block and the SYSREF gate sequencer.
// sysref_in is the same synchronised SYSREF that the downstream gate register samples.
interface sysref_gate_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO_W = 16
) ();
    logic             sysref_in;
    logic             start;
    logic             stop;
    logic             continuous;
    logic [CNT_W-1:0] num_pulses;
    logic [TMO_W-1:0] timeout_cycles;
    logic             enable_rclk;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output sysref_in, start, stop, continuous, num_pulses, timeout_cycles,
        input  enable_rclk, busy, done, timeout, pulse_count
    );

    modport slave (
        input  sysref_in, start, stop, continuous, num_pulses, timeout_cycles,
        output enable_rclk, busy, done, timeout, pulse_count
    );
endinterface

// File: rtl/sysref_gate_ctrl.sv
// SYSREF gate sequencer: opens the capture gate only on a SYSREF low and closes it only on a
// low/falling edge, so forwarded pulses are never truncated except by a timeout abort.
module sysref_gate_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO_W = 16
) (
    input  logic          rfdc_clk,
    input  logic          rfdc_rst,
    sysref_gate_if.slave  ctl
);

    typedef enum logic [1:0] {StIdle, StArm, StActive, StStopping} state_e;

    state_e           r_state, w_state_d;
    logic             r_sysref_prev;
    logic             r_cont, w_cont_d;
    logic [CNT_W-1:0] r_num, w_num_d;
    logic [TMO_W-1:0] r_tmo, w_tmo_d;
    logic [TMO_W-1:0] r_timer, w_timer_d;
    logic [CNT_W-1:0] r_count, w_count_d;
    logic             r_timeout, w_timeout_d;
    logic             r_done, w_done_d;
    logic             r_enable, w_enable_d;

    logic             w_fe;
    logic             w_low;
    logic             w_expire;
    logic [CNT_W-1:0] w_count_inc;
    logic [TMO_W-1:0] w_timer_inc;

    assign w_fe        = r_sysref_prev & ~ctl.sysref_in;
    assign w_low       = ~ctl.sysref_in;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_timer_inc = r_timer + TMO_W'(1);
    // Timer never exceeds T-1, so the increment cannot overflow before matching.
    assign w_expire    = (r_tmo != '0) && (w_timer_inc == r_tmo);

    always_comb begin
        w_state_d   = r_state;
        w_cont_d    = r_cont;
        w_num_d     = r_num;
        w_tmo_d     = r_tmo;
        w_timer_d   = r_timer;
        w_count_d   = r_count;
        w_timeout_d = r_timeout;
        w_done_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (ctl.start) begin
                    w_cont_d    = ctl.continuous;
                    w_num_d     = ctl.num_pulses;
                    w_tmo_d     = ctl.timeout_cycles;
                    w_count_d   = '0;
                    w_timeout_d = 1'b0;
                    w_timer_d   = '0;
                    if (!ctl.continuous && (ctl.num_pulses == '0)) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = StArm;
                    end
                end
            end

            StArm: begin
                if (ctl.stop) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else if (w_low) begin
                    w_state_d = StActive;
                    w_timer_d = '0;
                end else if (w_expire) begin
                    w_state_d   = StIdle;
                    w_done_d    = 1'b1;
                    w_timeout_d = 1'b1;
                    w_timer_d   = '0;
                end else begin
                    w_timer_d = w_timer_inc;
                end
            end

            StActive: begin
                if (w_fe) begin
                    // A falling edge beats both a stop and a timer expiry in the same cycle.
                    w_count_d = w_count_inc;
                    w_timer_d = '0;
                    if ((!r_cont && (w_count_inc == r_num)) || ctl.stop) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end
                end else if (ctl.stop && w_low) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else if (w_expire) begin
                    w_state_d   = StIdle;
                    w_done_d    = 1'b1;
                    w_timeout_d = 1'b1;
                    w_timer_d   = '0;
                end else if (ctl.stop) begin
                    w_state_d = StStopping;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = w_timer_inc;
                end
            end

            StStopping: begin
                if (w_fe) begin
                    w_count_d = w_count_inc;
                    w_timer_d = '0;
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else if (w_expire) begin
                    w_state_d   = StIdle;
                    w_done_d    = 1'b1;
                    w_timeout_d = 1'b1;
                    w_timer_d   = '0;
                end else begin
                    w_timer_d = w_timer_inc;
                end
            end

            default: w_state_d = StIdle;
        endcase

        w_enable_d = (w_state_d == StActive) || (w_state_d == StStopping);
    end

    always_ff @(posedge rfdc_clk) begin
        if (rfdc_rst) begin
            r_state       <= StIdle;
            r_sysref_prev <= 1'b0;
            r_cont        <= 1'b0;
            r_num         <= '0;
            r_tmo         <= '0;
            r_timer       <= '0;
            r_count       <= '0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_enable      <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_sysref_prev <= ctl.sysref_in;
            r_cont        <= w_cont_d;
            r_num         <= w_num_d;
            r_tmo         <= w_tmo_d;
            r_timer       <= w_timer_d;
            r_count       <= w_count_d;
            r_timeout     <= w_timeout_d;
            r_done        <= w_done_d;
            r_enable      <= w_enable_d;
        end
    end

    assign ctl.enable_rclk = r_enable;
    assign ctl.busy        = (r_state != StIdle);
    assign ctl.done        = r_done;
    assign ctl.timeout     = r_timeout;
    assign ctl.pulse_count = r_count;

endmodule

// File: tb/tb_sysref_gate_ctrl.sv
// Directed bench for sysref_gate_ctrl: a periodic SYSREF (period 32, high 8) or a held level,
// plus a model of the downstream gate that measures the length of every forwarded pulse.
module tb_sysref_gate_ctrl;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sysref_gate_if #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dif ();

    sysref_gate_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .rfdc_clk (clk),
        .rfdc_rst (rst),
        .ctl      (dif)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n, n_done, n_full, n_part, run, sr_ph;
    bit sr_run, ever_en;

    task automatic clear_stats();
        cyc_n = 0; n_done = 0; n_full = 0; n_part = 0; run = 0; ever_en = 1'b0;
    endtask

    // One clock: gate model sees the pre-edge values, outputs are read 1ns after the edge.
    task automatic cyc();
        if (dif.sysref_in && dif.enable_rclk) run++;
        else begin
            if (run == 8) n_full++;
            else if (run != 0) n_part++;
            run = 0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (dif.done) n_done++;
        if (dif.enable_rclk) ever_en = 1'b1;
        if (sr_run) begin
            sr_ph = (sr_ph + 1) % 32;
            dif.sysref_in = (sr_ph < 8);
        end
        dif.start = 1'b0;
        dif.stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        total++; if (dif.enable_rclk !== 1'b0) begin bad++; $display("FAIL reset_enable got=%0b want=0", dif.enable_rclk); end
        total++; if (dif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", dif.busy); end
        total++; if (dif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", dif.done); end
        total++; if (dif.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", dif.timeout); end
        total++; if (dif.pulse_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", dif.pulse_count); end
    endtask

    task automatic test_counted();
        sr_run = 1'b1; sr_ph = 16; dif.sysref_in = 1'b0;
        clear_stats();
        dif.continuous = 1'b0; dif.num_pulses = 8'd3; dif.timeout_cycles = 16'd0; dif.start = 1'b1;
        cyc();
        total++; if (dif.busy !== 1'b1) begin bad++; $display("FAIL counted_arm_busy got=%0b want=1", dif.busy); end
        total++; if (dif.enable_rclk !== 1'b0) begin bad++; $display("FAIL counted_arm_en got=%0b want=0", dif.enable_rclk); end
        cyc();
        total++; if (dif.enable_rclk !== 1'b1) begin bad++; $display("FAIL counted_latency2 got=%0b want=1", dif.enable_rclk); end
        while (!dif.done && cyc_n < 300) cyc();
        total++; if (cyc_n !== 89) begin bad++; $display("FAIL counted_done_cycle got=%0d want=89", cyc_n); end
        total++; if (dif.enable_rclk !== 1'b0) begin bad++; $display("FAIL counted_en_fall got=%0b want=0", dif.enable_rclk); end
        total++; if (dif.pulse_count !== 8'd3) begin bad++; $display("FAIL counted_count got=%0d want=3", dif.pulse_count); end
        repeat (40) cyc();
        total++; if (n_full !== 3 || n_part !== 0) begin bad++; $display("FAIL counted_pulses full=%0d part=%0d want=3/0", n_full, n_part); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL counted_done_once got=%0d want=1", n_done); end
        total++; if (dif.busy !== 1'b0) begin bad++; $display("FAIL counted_idle got=%0b want=0", dif.busy); end
    endtask

    task automatic test_armed_high();
        sr_run = 1'b1; sr_ph = 2; dif.sysref_in = 1'b1;
        clear_stats();
        dif.continuous = 1'b0; dif.num_pulses = 8'd1; dif.timeout_cycles = 16'd0; dif.start = 1'b1;
        cyc();
        repeat (5) cyc();
        total++; if (dif.enable_rclk !== 1'b0) begin bad++; $display("FAIL armhigh_closed got=%0b want=0", dif.enable_rclk); end
        cyc();
        total++; if (dif.enable_rclk !== 1'b1) begin bad++; $display("FAIL armhigh_open got=%0b want=1", dif.enable_rclk); end
        while (!dif.done && cyc_n < 200) cyc();
        total++; if (cyc_n !== 39) begin bad++; $display("FAIL armhigh_done_cycle got=%0d want=39", cyc_n); end
        total++; if (n_full !== 1 || n_part !== 0) begin bad++; $display("FAIL armhigh_pulses full=%0d part=%0d want=1/0", n_full, n_part); end
        total++; if (dif.pulse_count !== 8'd1) begin bad++; $display("FAIL armhigh_count got=%0d want=1", dif.pulse_count); end
    endtask

    task automatic test_cont_stop();
        sr_run = 1'b1; sr_ph = 16; dif.sysref_in = 1'b0;
        clear_stats();
        dif.continuous = 1'b1; dif.num_pulses = 8'd1; dif.timeout_cycles = 16'd0; dif.start = 1'b1;
        cyc();
        repeat (81) cyc();
        total++; if (dif.pulse_count !== 8'd2) begin bad++; $display("FAIL cont_count_mid got=%0d want=2", dif.pulse_count); end
        dif.stop = 1'b1;
        cyc();
        total++; if (dif.busy !== 1'b1 || dif.enable_rclk !== 1'b1) begin bad++; $display("FAIL cont_stopping busy=%0b en=%0b want=1/1", dif.busy, dif.enable_rclk); end
        while (!dif.done && cyc_n < 200) cyc();
        total++; if (cyc_n !== 89) begin bad++; $display("FAIL cont_stop_done_cycle got=%0d want=89", cyc_n); end
        total++; if (dif.pulse_count !== 8'd3) begin bad++; $display("FAIL cont_stop_count got=%0d want=3", dif.pulse_count); end
        total++; if (n_full !== 3 || n_part !== 0) begin bad++; $display("FAIL cont_stop_pulses full=%0d part=%0d want=3/0", n_full, n_part); end
        // Stop while SYSREF is low: straight back to idle.
        for (int i = 0; i < 40 && sr_ph != 12; i++) cyc();
        dif.start = 1'b1;
        cyc();
        cyc();
        total++; if (dif.enable_rclk !== 1'b1) begin bad++; $display("FAIL contlow_active got=%0b want=1", dif.enable_rclk); end
        dif.stop = 1'b1;
        cyc();
        total++; if (dif.busy !== 1'b0 || dif.done !== 1'b1 || dif.enable_rclk !== 1'b0) begin bad++; $display("FAIL contlow_stop busy=%0b done=%0b en=%0b want=0/1/0", dif.busy, dif.done, dif.enable_rclk); end
        total++; if (dif.pulse_count !== 8'd0) begin bad++; $display("FAIL contlow_count got=%0d want=0", dif.pulse_count); end
    endtask

    task automatic test_timeout();
        sr_run = 1'b0; dif.sysref_in = 1'b1;
        clear_stats();
        dif.continuous = 1'b0; dif.num_pulses = 8'd4; dif.timeout_cycles = 16'd100; dif.start = 1'b1;
        cyc();
        repeat (99) cyc();
        total++; if (dif.busy !== 1'b1 || dif.done !== 1'b0) begin bad++; $display("FAIL tmo_early busy=%0b done=%0b want=1/0", dif.busy, dif.done); end
        cyc();
        total++; if (dif.done !== 1'b1 || dif.timeout !== 1'b1 || dif.busy !== 1'b0) begin bad++; $display("FAIL tmo_abort done=%0b tmo=%0b busy=%0b want=1/1/0", dif.done, dif.timeout, dif.busy); end
        repeat (3) cyc();
        total++; if (dif.timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0b want=1", dif.timeout); end
        dif.timeout_cycles = 16'd0; dif.start = 1'b1;
        cyc();
        total++; if (dif.timeout !== 1'b0 || dif.busy !== 1'b1) begin bad++; $display("FAIL tmo_clear tmo=%0b busy=%0b want=0/1", dif.timeout, dif.busy); end
        dif.stop = 1'b1;
        cyc();
        total++; if (dif.done !== 1'b1 || dif.busy !== 1'b0) begin bad++; $display("FAIL arm_stop done=%0b busy=%0b want=1/0", dif.done, dif.busy); end
        total++; if (ever_en !== 1'b0) begin bad++; $display("FAIL tmo_never_enabled got=%0b want=0", ever_en); end
    endtask

    task automatic test_zero_and_ignored();
        sr_run = 1'b0; dif.sysref_in = 1'b0;
        clear_stats();
        dif.continuous = 1'b0; dif.num_pulses = 8'd0; dif.start = 1'b1;
        cyc();
        total++; if (dif.done !== 1'b1 || dif.busy !== 1'b0) begin bad++; $display("FAIL zero_done done=%0b busy=%0b want=1/0", dif.done, dif.busy); end
        cyc();
        total++; if (dif.done !== 1'b0 || ever_en !== 1'b0) begin bad++; $display("FAIL zero_after done=%0b en=%0b want=0/0", dif.done, ever_en); end
        // start while busy
        sr_run = 1'b1; sr_ph = 16; dif.sysref_in = 1'b0;
        clear_stats();
        dif.num_pulses = 8'd2; dif.start = 1'b1;
        cyc();
        repeat (29) cyc();
        dif.start = 1'b1; dif.continuous = 1'b1; dif.num_pulses = 8'd5;
        cyc();
        while (!dif.done && cyc_n < 300) cyc();
        total++; if (cyc_n !== 57 || dif.pulse_count !== 8'd2) begin bad++; $display("FAIL busy_start cycle=%0d count=%0d want=57/2", cyc_n, dif.pulse_count); end
        repeat (40) cyc();
        total++; if (n_done !== 1 || dif.busy !== 1'b0) begin bad++; $display("FAIL busy_start_once done=%0d busy=%0b want=1/0", n_done, dif.busy); end
        // start together with stop in idle
        clear_stats();
        dif.continuous = 1'b0; dif.num_pulses = 8'd1; dif.start = 1'b1; dif.stop = 1'b1;
        cyc();
        total++; if (dif.busy !== 1'b1) begin bad++; $display("FAIL startstop_busy got=%0b want=1", dif.busy); end
        while (!dif.done && cyc_n < 100) cyc();
        total++; if (dif.done !== 1'b1 || dif.pulse_count !== 8'd1) begin bad++; $display("FAIL startstop_end done=%0b count=%0d want=1/1", dif.done, dif.pulse_count); end
    endtask

    task automatic test_reset_mid();
        sr_run = 1'b1; sr_ph = 16; dif.sysref_in = 1'b0;
        clear_stats();
        dif.continuous = 1'b0; dif.num_pulses = 8'd5; dif.timeout_cycles = 16'd0; dif.start = 1'b1;
        cyc();
        repeat (50) cyc();
        total++; if (dif.pulse_count !== 8'd1 || dif.enable_rclk !== 1'b1) begin bad++; $display("FAIL rstmid_pre count=%0d en=%0b want=1/1", dif.pulse_count, dif.enable_rclk); end
        rst = 1'b1;
        cyc();
        total++; if (dif.enable_rclk !== 1'b0 || dif.busy !== 1'b0 || dif.done !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl en=%0b busy=%0b done=%0b want=0/0/0", dif.enable_rclk, dif.busy, dif.done); end
        total++; if (dif.timeout !== 1'b0 || dif.pulse_count !== 8'd0) begin bad++; $display("FAIL rstmid_status tmo=%0b count=%0d want=0/0", dif.timeout, dif.pulse_count); end
        rst = 1'b0;
        clear_stats();
        dif.num_pulses = 8'd1; dif.start = 1'b1;
        cyc();
        total++; if (dif.busy !== 1'b1 || dif.pulse_count !== 8'd0) begin bad++; $display("FAIL rstmid_restart busy=%0b count=%0d want=1/0", dif.busy, dif.pulse_count); end
        while (!dif.done && cyc_n < 100) cyc();
        total++; if (cyc_n !== 37 || dif.pulse_count !== 8'd1) begin bad++; $display("FAIL rstmid_fresh cycle=%0d count=%0d want=37/1", cyc_n, dif.pulse_count); end
        total++; if (n_full !== 1 || n_part !== 0) begin bad++; $display("FAIL rstmid_pulses full=%0d part=%0d want=1/0", n_full, n_part); end
    endtask

    initial begin
        rst = 1'b1;
        sr_run = 1'b0; sr_ph = 0;
        dif.sysref_in = 1'b0; dif.start = 1'b0; dif.stop = 1'b0; dif.continuous = 1'b0;
        dif.num_pulses = 8'd0; dif.timeout_cycles = 16'd0;
        clear_stats();
        test_reset();
        test_counted();
        test_armed_high();
        test_cont_stop();
        test_timeout();
        test_zero_and_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=expired want=finished");
        $fatal(1);
    end
endmodule

// File: doc/sysref_gate_ctrl.md
# sysref_gate_ctrl

Sequencer for the SYSREF gate in the rfdc_clk domain. It drives the `enable_rclk` input of the SYSREF capture stage. The gate opens only while SYSREF is low, and it closes only on a SYSREF low or falling edge, so the RFDC never receives a truncated pulse. Software can request a counted burst of N SYSREF pulses or continuous forwarding. The block reports progress, completion and timeout back to the control register block.

## Interface
- `CNT_W`, 8: width of the pulse-count request and status.
- `TMO_W`, 16: width of the timeout cycle count.

Ports:
- `rfdc_clk` in 1: sole clock.
- `rfdc_rst` in 1: reset, synchronous, active-high.
- `sysref_in` in 1: ungated SYSREF already synchronised to rfdc_clk. This is the same signal the gate register samples.
- `start` in 1: single-cycle request to begin a sequence.
- `stop` in 1: single-cycle request to end a sequence at the next SYSREF low.
- `continuous` in 1: sampled with `start`. 1 means ignore `num_pulses` and run until `stop`.
- `num_pulses` in CNT_W: sampled with `start`. Number of complete pulses to forward.
- `timeout_cycles` in TMO_W: sampled with `start`. 0 disables the timeout.
- `enable_rclk` out 1: gate enable to the capture stage. Registered.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: single-cycle pulse on every return to IDLE.
- `timeout` out 1: sticky. Set on timeout abort; cleared by reset or an accepted `start`.
- `pulse_count` out CNT_W: number of complete pulses forwarded since the last accepted `start`.

## Operation
- States: IDLE, ARM, ACTIVE, STOPPING.
- Falling edge (fe) = previous registered `sysref_in` was 1 and current `sysref_in` is 0. The previous-sample register resets to 0.
- **IDLE**
  - `start` is accepted: latch `continuous`, `num_pulses` and `timeout_cycles`; clear `pulse_count`, `timeout` and the timer.
  - If `continuous`=0 and `num_pulses`=0, stay in IDLE and pulse `done` next cycle; the gate is never enabled.
  - Otherwise go to ARM.
  - `stop` is ignored. If `start` and `stop` arrive in the same cycle, `start` is accepted and `stop` is discarded.
- **ARM**
  - Wait for `sysref_in`=0.
  - On that cycle go to ACTIVE and set `enable_rclk`=1.
  - `stop` goes to IDLE with `done` asserted, without ever enabling.
- **ACTIVE**
  - `enable_rclk`=1.
  - Each fe increments `pulse_count`. The count wraps modulo 2^CNT_W only in continuous mode.
  - Counted mode: the fe that brings `pulse_count` to `num_pulses` goes to IDLE, with `enable_rclk`=0 and `done`.
  - `stop`:
    - If `sysref_in`=0 in the same cycle, go to IDLE immediately.
    - Otherwise go to STOPPING.
- **STOPPING**
  - `enable_rclk` stays 1.
  - The next fe increments `pulse_count` and goes to IDLE with `done`.
- **Timeout**
  - Applies in ARM, ACTIVE and STOPPING when `timeout_cycles`=T≠0.
  - The timer clears on state entry and on every fe, and increments otherwise.
  - On the T-th consecutive cycle without a fe (or without a low, while in ARM), go to IDLE immediately, even if SYSREF is high. Set `enable_rclk`=0, set `timeout`=1, pulse `done`.
  - A fault abort may truncate a pulse; this is accepted.
- Simultaneous events:
  - fe completes the count in the same cycle as `stop`: one `done`, count includes that pulse.
  - fe in the same cycle as timer expiry: the fe wins and the timer clears.
  - `start` while `busy`: ignored.
- Reset mid-operation: next cycle is IDLE, all outputs 0. The downstream gate closes one cycle later.

## Timing
- Reset values: `enable_rclk`=0, `busy`=0, `done`=0, `timeout`=0, `pulse_count`=0. State is IDLE.
- `start` sampled at edge t. State is ARM after t. If `sysref_in`=0 at edge t+1, `enable_rclk`=1 after t+1. Minimum start-to-enable latency is 2 cycles.
- `enable_rclk` falls on the cycle after the qualifying low/fe sample. Because the gate samples `sysref_in`=0 on that same edge, the last forwarded pulse is complete.
- `done` is asserted for exactly the one cycle in which `busy` first reads 0.
- `pulse_count` updates on the cycle after the fe.

## Test plan
- **Counted burst.** SYSREF with period 32 cycles, high 8. `start`, `num_pulses`=3, T=0.
  - Gate output carries exactly 3 full 8-cycle pulses.
  - `pulse_count`=3; `done` once; `enable_rclk` falls the cycle after the 3rd fe.
- **Armed while high.** `start` issued mid-pulse (SYSREF high).
  - `enable_rclk` stays 0 until the first low sample.
  - The partial pulse is not forwarded.
- **Continuous stop.** `continuous`=1.
  - `stop` while high: STOPPING, the pulse completes, then `done`; count includes it.
  - `stop` while low: IDLE on the next cycle.
- **Timeout.** SYSREF held at 1, `num_pulses`=4, T=100.
  - `timeout`=1 and `done` 100 cycles after ARM entry; `enable_rclk`=0 throughout.
  - A second `start` clears `timeout`.
- **Zero and ignored requests.**
  - `num_pulses`=0 with `continuous`=0: `done` 1 cycle after `start`, `enable_rclk` never 1.
  - `start` while `busy`: no effect on count or config.
  - `start` together with `stop` in IDLE: sequence starts.
- **Reset mid-ACTIVE.** Assert `rfdc_rst` for 1 cycle during pulse 2 of 5.
  - All outputs 0 the next cycle, state IDLE.
  - A subsequent `start` behaves as a fresh burst.
